// File: rtl/torpedo_pool_if.sv
// Handshake bundle between the fire/frame logic and the torpedo slot manager.
// master drives requests and frame ticks; slave is torpedo_pool_ctrl.
interface torpedo_pool_if #(
  parameter int T_NUM = 4
);
  localparam int CNT_W = $clog2(T_NUM + 1);

  logic             vsync_pulse;
  logic             fire;
  logic [T_NUM-1:0] hit;
  logic             clear;
  logic [T_NUM-1:0] launch;
  logic [T_NUM-1:0] active;
  logic [CNT_W-1:0] count;
  logic             busy;

  modport master (
    output vsync_pulse, fire, hit, clear,
    input  launch, active, count, busy
  );

  modport slave (
    input  vsync_pulse, fire, hit, clear,
    output launch, active, count, busy
  );
endinterface

// File: rtl/torpedo_pool_ctrl.sv
// Central torpedo slot manager: lowest-free allocation, lifetime expiry, hit release, cooldown.
// Optional macro TORPEDO_AUTOFIRE_EN: fire is level-sensitive (auto-repeat) instead of edge-triggered.
module torpedo_pool_ctrl #(
  parameter int T_NUM    = 4,
  parameter int LIFETIME = 60,
  parameter int COOLDOWN = 8
) (
  input  logic           clk,
  input  logic           resetN,
  torpedo_pool_if.slave  bus
);
  localparam int CNT_W = $clog2(T_NUM + 1);
  localparam int AGE_W = $clog2(LIFETIME + 1);
  localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(LIFETIME - 1);
  localparam logic [CD_W-1:0]  CD_INIT  = CD_W'(COOLDOWN);

  logic [T_NUM-1:0] active, active_nxt;
  logic [T_NUM-1:0] launch, launch_nxt;
  logic [AGE_W-1:0] age     [T_NUM];
  logic [AGE_W-1:0] age_nxt [T_NUM];
  logic [CD_W-1:0]  cooldown, cooldown_nxt;
  logic [CNT_W-1:0] count;
  logic             fire_d;
  logic             fire_ok;
  logic             req;

  // One-hot of the lowest clear bit; all-ones input yields zero.
  function automatic logic [T_NUM-1:0] lowest_free(input logic [T_NUM-1:0] act);
    return ~act & (act + T_NUM'(1));
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [T_NUM-1:0] act);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < T_NUM; i++) c = c + CNT_W'(act[i]);
    return c;
  endfunction

  // fire_d resets high so a button held through reset never fires.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) fire_d <= 1'b1;
    else         fire_d <= bus.fire;
  end

`ifdef TORPEDO_AUTOFIRE_EN
  logic armed;

  // Auto-repeat only after fire has been seen low once since reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)      armed <= 1'b0;
    else if (!fire_d) armed <= 1'b1;
  end

  assign fire_ok = bus.fire && (armed || !fire_d);
`else
  assign fire_ok = bus.fire && !fire_d;
`endif

  assign req = fire_ok && (cooldown == '0) && !(&active) && !bus.clear;

  always_comb begin
    launch_nxt   = req ? lowest_free(active) : '0;
    cooldown_nxt = cooldown;
    if (bus.clear)                                cooldown_nxt = '0;
    else if (req)                                 cooldown_nxt = CD_INIT;
    else if (bus.vsync_pulse && cooldown != '0)   cooldown_nxt = cooldown - CD_W'(1);

    for (int i = 0; i < T_NUM; i++) begin
      active_nxt[i] = active[i];
      age_nxt[i]    = age[i];
      if (bus.clear) begin
        active_nxt[i] = 1'b0;
        age_nxt[i]    = '0;
      end else if (launch_nxt[i]) begin
        active_nxt[i] = 1'b1;
        age_nxt[i]    = '0;
      end else if (active[i]) begin
        if (bus.vsync_pulse) begin
          if (age[i] == AGE_LAST) begin
            active_nxt[i] = 1'b0;
            age_nxt[i]    = '0;
          end else begin
            age_nxt[i]    = age[i] + AGE_W'(1);
          end
        end
        if (bus.hit[i]) active_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      launch   <= '0;
      active   <= '0;
      count    <= '0;
      cooldown <= '0;
      for (int i = 0; i < T_NUM; i++) age[i] <= '0;
    end else begin
      launch   <= launch_nxt;
      active   <= active_nxt;
      count    <= popcount(active_nxt);
      cooldown <= cooldown_nxt;
      for (int i = 0; i < T_NUM; i++) age[i] <= age_nxt[i];
    end
  end

  assign bus.launch = launch;
  assign bus.active = active;
  assign bus.count  = count;
  assign bus.busy   = (cooldown != '0) || (&active);

endmodule

// File: tb/tb_torpedo_pool_ctrl.sv
// Directed bench: d0 has no cooldown (allocation, hits, expiry, clear); d8 has an 8-frame cooldown.
`timescale 1ns/1ps
module tb_torpedo_pool_ctrl;
  logic clk = 1'b0;
  logic resetN;
  int   n_checks = 0;
  int   n_errors = 0;

  always #20 clk = ~clk;

  torpedo_pool_if #(.T_NUM(4)) if0 ();
  torpedo_pool_if #(.T_NUM(4)) if8 ();

  torpedo_pool_ctrl #(.T_NUM(4), .LIFETIME(60), .COOLDOWN(0)) d0 (
    .clk(clk), .resetN(resetN), .bus(if0)
  );
  torpedo_pool_ctrl #(.T_NUM(4), .LIFETIME(60), .COOLDOWN(8)) d8 (
    .clk(clk), .resetN(resetN), .bus(if8)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vsync0();
    if0.vsync_pulse = 1'b1; tick(); if0.vsync_pulse = 1'b0; tick();
  endtask

  task automatic vsync8();
    if8.vsync_pulse = 1'b1; tick(); if8.vsync_pulse = 1'b0; tick();
  endtask

  logic [3:0] seen;
  int         hold_exp;

  initial begin
    resetN = 1'b0;
    if0.vsync_pulse = 0; if0.fire = 1; if0.hit = '0; if0.clear = 0;
    if8.vsync_pulse = 0; if8.fire = 1; if8.hit = '0; if8.clear = 0;
    repeat (3) tick();
    check_eq("rst_launch", 32'(if0.launch), 0);
    check_eq("rst_active", 32'(if0.active), 0);
    check_eq("rst_count",  32'(if0.count),  0);
    check_eq("rst_busy8",  32'(if8.busy),   0);

    // Fire held across reset release must not launch.
    resetN = 1'b1;
    seen = '0;
    repeat (100) begin
      tick();
      seen = seen | if0.launch | if0.active | if8.launch | if8.active;
    end
    check_eq("held_no_launch", 32'(seen), 0);
    check_eq("held_count", 32'(if0.count), 0);
    if0.fire = 0; if8.fire = 0;
    tick();

    // Fill the pool in order, then a dropped fifth request.
    for (int k = 0; k < 4; k++) begin
      if0.fire = 1; tick();
      check_eq($sformatf("fill_launch%0d", k), 32'(if0.launch), 32'(1 << k));
      if0.fire = 0; tick();
      check_eq($sformatf("fill_strobe%0d", k), 32'(if0.launch), 0);
      tick();
    end
    check_eq("full_active", 32'(if0.active), 32'hF);
    check_eq("full_count",  32'(if0.count),  4);
    check_eq("full_busy",   32'(if0.busy),   1);
    if0.fire = 1; tick();
    check_eq("fifth_dropped", 32'(if0.launch), 0);
    check_eq("fifth_active",  32'(if0.active), 32'hF);
    if0.fire = 0; tick();

    // Hits release slots; lowest free slot is reused.
    if0.hit = 4'b0100; tick(); if0.hit = '0;
    check_eq("hit2_active", 32'(if0.active), 32'hB);
    check_eq("hit2_busy",   32'(if0.busy),   0);
    if0.hit = 4'b0010; tick(); if0.hit = '0;
    check_eq("hit1_active", 32'(if0.active), 32'h9);
    check_eq("hit1_count",  32'(if0.count),  2);
    if0.hit = 4'b0110; tick(); if0.hit = '0;
    check_eq("hit_idle_ignored", 32'(if0.active), 32'h9);
    if0.fire = 1; tick(); if0.fire = 0;
    check_eq("reuse_launch", 32'(if0.launch), 32'h2);
    check_eq("reuse_active", 32'(if0.active), 32'hB);
    tick();
    // Hit slot 3 while launching into slot 2.
    if0.fire = 1; if0.hit = 4'b1000; tick(); if0.fire = 0; if0.hit = '0;
    check_eq("hitj_launchk_launch", 32'(if0.launch), 32'h4);
    check_eq("hitj_launchk_active", 32'(if0.active), 32'h7);
    check_eq("hitj_launchk_count",  32'(if0.count),  3);
    tick();
    // Hit on the slot being launched into is ignored.
    if0.fire = 1; if0.hit = 4'b1000; tick(); if0.fire = 0; if0.hit = '0;
    check_eq("hit_same_launch", 32'(if0.launch), 32'h8);
    check_eq("hit_same_active", 32'(if0.active), 32'hF);
    tick();

    // Clear with a same-cycle hit and fire edge.
    if0.clear = 1; if0.hit = 4'b0100; if0.fire = 1; tick();
    if0.clear = 0; if0.hit = '0; if0.fire = 0;
    check_eq("clear_active", 32'(if0.active), 0);
    check_eq("clear_count",  32'(if0.count),  0);
    check_eq("clear_launch", 32'(if0.launch), 0);
    check_eq("clear_busy",   32'(if0.busy),   0);
    tick();

    // Lifetime: alive after 59 frames, gone after the 60th.
    if0.fire = 1; tick(); if0.fire = 0;
    check_eq("life_launch", 32'(if0.launch), 32'h1);
    tick();
    repeat (59) vsync0();
    check_eq("life_59", 32'(if0.active), 32'h1);
    vsync0();
    check_eq("life_60_active", 32'(if0.active), 0);
    check_eq("life_60_count",  32'(if0.count),  0);

    // Hit and expiry on the same slot in the same cycle.
    if0.fire = 1; tick(); if0.fire = 0; tick();
    repeat (59) vsync0();
    if0.vsync_pulse = 1; if0.hit = 4'b0001; tick();
    if0.vsync_pulse = 0; if0.hit = '0;
    check_eq("hit_expiry_active", 32'(if0.active), 0);
    check_eq("hit_expiry_count",  32'(if0.count),  0);
    tick();

    // Holding fire: one launch edge-triggered, pool fill with auto-repeat.
`ifdef TORPEDO_AUTOFIRE_EN
    hold_exp = 4;
`else
    hold_exp = 1;
`endif
    if0.fire = 1; repeat (6) tick(); if0.fire = 0; tick();
    check_eq("hold_count", 32'(if0.count), 32'(hold_exp));
    if0.clear = 1; tick(); if0.clear = 0; tick();

    // Cooldown on d8.
    if8.fire = 1; tick(); if8.fire = 0;
    check_eq("cd_launch0", 32'(if8.launch), 32'h1);
    check_eq("cd_busy0",   32'(if8.busy),   1);
    tick();
    repeat (7) vsync8();
    if8.fire = 1; tick(); if8.fire = 0;
    check_eq("cd_7_dropped", 32'(if8.launch), 0);
    check_eq("cd_7_busy",    32'(if8.busy),   1);
    tick();
    vsync8();
    check_eq("cd_8_busy", 32'(if8.busy), 0);
    // Launch coinciding with vsync restarts the full cooldown.
    if8.fire = 1; if8.vsync_pulse = 1; tick(); if8.fire = 0; if8.vsync_pulse = 0;
    check_eq("cd_8_launch", 32'(if8.launch), 32'h2);
    tick();
    repeat (7) vsync8();
    check_eq("cd_vs_busy7", 32'(if8.busy), 1);
    vsync8();
    check_eq("cd_vs_busy8", 32'(if8.busy), 0);
    if8.fire = 1; tick(); if8.fire = 0;
    check_eq("cd_launch2", 32'(if8.launch), 32'h4);
    tick();
    if8.clear = 1; tick(); if8.clear = 0;
    check_eq("cd_clear_busy",   32'(if8.busy),   0);
    check_eq("cd_clear_active", 32'(if8.active), 0);
    if8.fire = 1; tick(); if8.fire = 0;
    check_eq("cd_after_clear", 32'(if8.launch), 32'h1);
    tick();

    // Asynchronous reset mid-flight.
    if0.fire = 1; tick(); if0.fire = 0;
    #5 resetN = 1'b0;
    #1;
    check_eq("async_rst_active0", 32'(if0.active), 0);
    check_eq("async_rst_active8", 32'(if8.active), 0);
    check_eq("async_rst_count0",  32'(if0.count),  0);
    tick(); tick();
    resetN = 1'b1;
    seen = '0;
    repeat (3) begin
      tick();
      seen = seen | if0.launch | if8.launch;
    end
    check_eq("rst_release_no_launch", 32'(seen), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
